uart_cmd_ctrl: RTL and testbench

Byte-level sequencer that sits behind the UART receiver and consumes its `rdy`/`rx_data` handshake. It hunts for sync bytes, assembles multi-byte command frames into a parallel command word, and presents that word to the core with a sticky ready/clear handshake. It also owns the receiver's `baud` divisor register, which is reprogrammable through a config frame. It detects inter-byte timeouts and command overrun.

---
 rtl/uart_cmd_ctrl.sv | 161 ++++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// UART byte sequencer: sync hunt, command/baud-config frame assembly, sticky cmd_rdy handshake, inter-byte timeout.
// Latency: cmd/cmd_rdy/baud update 1 clk after the last byte capture; one byte per 2 clk (capture + clr_rdy). Option: UART_CMD_CHKSUM_EN.
module uart_cmd_ctrl #(
    parameter int          CMD_BYTES    = 2,
    parameter int          TIMEOUT_CLKS = 20000,
    parameter logic [12:0] BAUD_RST     = 13'h1B2,
    parameter logic [7:0]  SYNC_CMD     = 8'hA5,
    parameter logic [7:0]  SYNC_CFG     = 8'h5A
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_rx_rdy,
    input  logic [7:0]             i_rx_data,
    output logic                   o_clr_rdy,
    output logic [12:0]            o_baud,
    output logic [8*CMD_BYTES-1:0] o_cmd,
    output logic                   o_cmd_rdy,
    input  logic                   i_clr_cmd_rdy,
    output logic                   o_overrun,
    output logic                   o_frame_err
);

    localparam int W  = 8 * CMD_BYTES;
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
`ifdef UART_CMD_CHKSUM_EN
    localparam int FRAME_BYTES = CMD_BYTES + 1;
`else
    localparam int FRAME_BYTES = CMD_BYTES;
`endif

    typedef enum logic [1:0] {S_HUNT, S_PAYLOAD, S_CFG} state_t;

    state_t         r_state, w_state_nxt;
    logic           r_clr_rdy;
    logic [2:0]     r_idx;
    logic [TW-1:0]  r_tmo;
    logic [W-1:0]   r_frame;
    logic [4:0]     r_cfg_hi;
    logic [12:0]    r_baud;
    logic [W-1:0]   r_cmd;
    logic           r_cmd_rdy;
    logic           r_overrun;
    logic           r_frame_err;

    logic           w_capture;
    logic           w_timeout;
    logic           w_accept;
    logic           w_cfg_done;
    logic           w_bad_sum;
    logic [W-1:0]   w_frame_shift;
    logic [W-1:0]   w_word;

`ifdef UART_CMD_CHKSUM_EN
    logic [7:0]     r_sum;
    logic [7:0]     w_sum;
    assign w_sum = r_sum + i_rx_data;
`endif

    // A byte still flagged while clr_rdy is out is the one just taken.
    assign w_capture     = i_rx_rdy && !r_clr_rdy;
    assign w_frame_shift = W'({r_frame, i_rx_data});
    assign w_timeout     = (r_state != S_HUNT) && !w_capture && (r_tmo == TW'(TIMEOUT_CLKS));

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_HUNT;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_cfg_done  = 1'b0;
        w_bad_sum   = 1'b0;
        w_word      = w_frame_shift;
        case (r_state)
            S_HUNT: begin
                if (w_capture && i_rx_data == SYNC_CMD)      w_state_nxt = S_PAYLOAD;
                else if (w_capture && i_rx_data == SYNC_CFG) w_state_nxt = S_CFG;
            end
            S_PAYLOAD: begin
                if (w_timeout) begin
                    w_state_nxt = S_HUNT;
                end else if (w_capture && r_idx == 3'(FRAME_BYTES - 1)) begin
                    w_state_nxt = S_HUNT;
`ifdef UART_CMD_CHKSUM_EN
                    // Last byte is the checksum; the payload is already in r_frame.
                    w_word = r_frame;
                    if (w_sum == 8'h00) w_accept  = 1'b1;
                    else                w_bad_sum = 1'b1;
`else
                    w_accept = 1'b1;
`endif
                end
            end
            S_CFG: begin
                if (w_timeout) begin
                    w_state_nxt = S_HUNT;
                end else if (w_capture && r_idx == 3'd1) begin
                    w_cfg_done  = 1'b1;
                    w_state_nxt = S_HUNT;
                end
            end
            default: w_state_nxt = S_HUNT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_clr_rdy   <= 1'b0;
            r_idx       <= 3'd0;
            r_tmo       <= '0;
            r_frame     <= '0;
            r_cfg_hi    <= 5'd0;
            r_baud      <= BAUD_RST;
            r_cmd       <= '0;
            r_cmd_rdy   <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef UART_CMD_CHKSUM_EN
            r_sum       <= 8'h00;
`endif
        end else begin
            r_clr_rdy   <= w_capture;
            r_frame_err <= w_timeout || w_bad_sum;

            if (w_capture || r_state == S_HUNT || w_timeout) r_tmo <= '0;
            else if (r_tmo != TW'(TIMEOUT_CLKS))             r_tmo <= r_tmo + TW'(1);

            if (w_capture) r_idx <= (r_state == S_HUNT) ? 3'd0 : r_idx + 3'd1;

            if (w_capture && r_state == S_PAYLOAD) r_frame <= w_frame_shift;
`ifdef UART_CMD_CHKSUM_EN
            if (w_capture) r_sum <= (r_state == S_HUNT) ? 8'h00 : w_sum;
`endif
            if (w_capture && r_state == S_CFG && r_idx == 3'd0) r_cfg_hi <= i_rx_data[4:0];
            if (w_cfg_done) r_baud <= {r_cfg_hi, i_rx_data};

            // Later assignments win: an accept overrides a simultaneous acknowledge.
            if (i_clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
                r_overrun <= 1'b0;
            end
            if (w_accept) begin
                if (!r_cmd_rdy) begin
                    r_cmd     <= w_word;
                    r_cmd_rdy <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end
        end
    end

    assign o_clr_rdy   = r_clr_rdy;
    assign o_baud      = r_baud;
    assign o_cmd       = r_cmd;
    assign o_cmd_rdy   = r_cmd_rdy;
    assign o_overrun   = r_overrun;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: byte-vector table plus hand sequences for timeout, reset and same-cycle handshakes.
module tb_uart_cmd_ctrl;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_cmd_rdy = 1'b0;
    logic        clr_rdy;
    logic [12:0] baud;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        overrun;
    logic        frame_err;

    int total = 0;
    int bad   = 0;
    int n_clr = 0;

    uart_cmd_ctrl #(.CMD_BYTES(2), .TIMEOUT_CLKS(TMO)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_rx_rdy      (rx_rdy),
        .i_rx_data     (rx_data),
        .o_clr_rdy     (clr_rdy),
        .o_baud        (baud),
        .o_cmd         (cmd),
        .o_cmd_rdy     (cmd_rdy),
        .i_clr_cmd_rdy (clr_cmd_rdy),
        .o_overrun     (overrun),
        .o_frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (clr_rdy) n_clr++;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          op_clr;
        logic [7:0]  b;
        logic [15:0] cmd;
        logic        rdy;
        logic        ovr;
        logic [12:0] baud;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Receiver model: hold rx_rdy until clr_rdy is seen, then drop it.
    task automatic send_byte(input logic [7:0] b, input bit with_clr);
        int n;
        @(negedge clk);
        rx_rdy      = 1'b1;
        rx_data     = b;
        clr_cmd_rdy = with_clr;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        n = 0;
        while (!clr_rdy && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("clr_rdy_seen", clr_rdy, 1'b1);
        rx_rdy = 1'b0;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        int n0, first, cnt;

        repeat (3) @(negedge clk);
        chk("rst_clr_rdy", clr_rdy, 1'b0);
        chk("rst_baud", baud, 13'h1B2);
        chk("rst_cmd", cmd, 16'h0000);
        chk("rst_cmd_rdy", cmd_rdy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        chk("rst_frame_err", frame_err, 1'b0);
        rst = 1'b0;

`ifdef UART_CMD_CHKSUM_EN
        send_byte(8'hA5, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'hBA, 0);
        chk("cs_good_cmd", cmd, 16'h1234);
        chk("cs_good_rdy", cmd_rdy, 1'b1);
        chk("cs_good_ferr", frame_err, 1'b0);
        pulse_clr();
        send_byte(8'hA5, 0); send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'hBB, 0);
        chk("cs_bad_ferr", frame_err, 1'b1);
        chk("cs_bad_rdy", cmd_rdy, 1'b0);
        chk("cs_bad_cmd", cmd, 16'h1234);
        @(negedge clk);
        chk("cs_bad_ferr_pulse", frame_err, 1'b0);
`else
        tv.push_back('{0, 8'hA5, 16'h0000, 0, 0, 13'h1B2});
        tv.push_back('{0, 8'h12, 16'h0000, 0, 0, 13'h1B2});
        tv.push_back('{0, 8'h34, 16'h1234, 1, 0, 13'h1B2});
        tv.push_back('{1, 8'h00, 16'h1234, 0, 0, 13'h1B2});
        tv.push_back('{0, 8'h00, 16'h1234, 0, 0, 13'h1B2});
        tv.push_back('{0, 8'hFF, 16'h1234, 0, 0, 13'h1B2});
        tv.push_back('{0, 8'h5A, 16'h1234, 0, 0, 13'h1B2});
        tv.push_back('{0, 8'h03, 16'h1234, 0, 0, 13'h1B2});
        tv.push_back('{0, 8'hFF, 16'h1234, 0, 0, 13'h03FF});
        tv.push_back('{0, 8'hA5, 16'h1234, 0, 0, 13'h03FF});
        tv.push_back('{0, 8'h11, 16'h1234, 0, 0, 13'h03FF});
        tv.push_back('{0, 8'h22, 16'h1122, 1, 0, 13'h03FF});
        tv.push_back('{0, 8'hA5, 16'h1122, 1, 0, 13'h03FF});
        tv.push_back('{0, 8'h33, 16'h1122, 1, 0, 13'h03FF});
        tv.push_back('{0, 8'h44, 16'h1122, 1, 1, 13'h03FF});
        tv.push_back('{1, 8'h00, 16'h1122, 0, 0, 13'h03FF});
        tv.push_back('{0, 8'h5A, 16'h1122, 0, 0, 13'h03FF});
        tv.push_back('{0, 8'hE1, 16'h1122, 0, 0, 13'h03FF});
        tv.push_back('{0, 8'h23, 16'h1122, 0, 0, 13'h0123});
        tv.push_back('{0, 8'hA5, 16'h1122, 0, 0, 13'h0123});
        tv.push_back('{0, 8'h5A, 16'h1122, 0, 0, 13'h0123});
        tv.push_back('{0, 8'hA5, 16'h5AA5, 1, 0, 13'h0123});
        tv.push_back('{1, 8'h00, 16'h5AA5, 0, 0, 13'h0123});

        n0 = n_clr;
        for (int i = 0; i < tv.size(); i++) begin
            if (tv[i].op_clr) pulse_clr();
            else              send_byte(tv[i].b, 0);
            chk($sformatf("v%0d_cmd", i), cmd, tv[i].cmd);
            chk($sformatf("v%0d_cmd_rdy", i), cmd_rdy, tv[i].rdy);
            chk($sformatf("v%0d_overrun", i), overrun, tv[i].ovr);
            chk($sformatf("v%0d_baud", i), baud, tv[i].baud);
            chk($sformatf("v%0d_frame_err", i), frame_err, 1'b0);
        end
        chk("clr_rdy_pulse_count", n_clr - n0, 20);

        // Inter-byte timeout: pulse lands TMO+1 cycles after the last capture.
        send_byte(8'hA5, 0); send_byte(8'h12, 0);
        first = 0;
        cnt   = 0;
        for (int i = 1; i <= TMO + 5; i++) begin
            @(negedge clk);
            if (frame_err) begin
                if (first == 0) first = i;
                cnt++;
            end
        end
        chk("tmo_first_cycle", first, TMO + 1);
        chk("tmo_pulse_len", cnt, 1);
        chk("tmo_cmd_kept", cmd, 16'h5AA5);
        chk("tmo_cmd_rdy", cmd_rdy, 1'b0);
        send_byte(8'hA5, 0); send_byte(8'h56, 0); send_byte(8'h78, 0);
        chk("post_tmo_cmd", cmd, 16'h5678);
        chk("post_tmo_rdy", cmd_rdy, 1'b1);
        pulse_clr();

        // Reset in the middle of a frame.
        send_byte(8'hA5, 0); send_byte(8'h12, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_baud", baud, 13'h1B2);
        chk("mid_rst_cmd", cmd, 16'h0000);
        chk("mid_rst_rdy", cmd_rdy, 1'b0);
        send_byte(8'h34, 0); send_byte(8'hA5, 0); send_byte(8'hAB, 0); send_byte(8'hCD, 0);
        chk("post_rst_cmd", cmd, 16'hABCD);
        chk("post_rst_rdy", cmd_rdy, 1'b1);
        pulse_clr();
        chk("post_rst_clr", cmd_rdy, 1'b0);

        // Acknowledge in the same cycle as an accept, then as an overrun.
        send_byte(8'hA5, 0); send_byte(8'h99, 0); send_byte(8'h77, 1);
        chk("same_acc_cmd", cmd, 16'h9977);
        chk("same_acc_rdy", cmd_rdy, 1'b1);
        chk("same_acc_ovr", overrun, 1'b0);
        send_byte(8'hA5, 0); send_byte(8'h88, 0); send_byte(8'h66, 1);
        chk("same_ovr_ovr", overrun, 1'b1);
        chk("same_ovr_cmd", cmd, 16'h9977);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
